dac_softstart_gate: RTL and testbench

//  Output stage between the 14-bit offset-binary sine source and the external DAC pins.

---
 rtl/octacq_dac_pkg.sv | 14 +
 rtl/gain_ramp_ctrl.sv | 104 ++++++++++
 rtl/dac_softstart_gate.sv | 68 ++++++
 tb/tb_dac_softstart_gate.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/octacq_dac_pkg.sv
// Shared constants and types for the DAC output stage.
package octacq_dac_pkg;

  localparam logic [13:0] MIDSCALE   = 14'h2000;
  localparam logic [8:0]  UNITY_GAIN = 9'd256;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRampUp   = 2'd1,
    StRun      = 2'd2,
    StRampDown = 2'd3
  } ramp_state_e;

endpackage

// File: rtl/gain_ramp_ctrl.sv
// Soft-start gain sequencer: ramps gain 0 <-> unity one LSB every RAMP_DIV cycles.
module gain_ramp_ctrl
  import octacq_dac_pkg::*;
#(
  parameter int unsigned GAIN_W   = 9,
  parameter int unsigned RAMP_DIV = 50
) (
  input  logic              clk50MHz,
  input  logic              rstn,
  input  logic              enable,
  output logic [GAIN_W-1:0] gain,
  output logic              ramp_busy,
  output logic              at_full
);

  localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(1) << (GAIN_W - 1);
  localparam logic [GAIN_W-1:0] ONE      = GAIN_W'(1);

  ramp_state_e       state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic              busy_q, busy_d;
  logic              full_q, full_d;

  always_ff @(posedge clk50MHz or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      div_q   <= '0;
      gain_q  <= '0;
      busy_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      gain_q  <= gain_d;
      busy_q  <= busy_d;
      full_q  <= full_d;
    end
  end

  // Divider clears on every state change so each first step takes a full period.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    gain_d  = gain_q;
    case (state_q)
      StIdle: begin
        gain_d = '0;
        div_d  = '0;
        if (enable) state_d = StRampUp;
      end
      StRampUp: begin
        if (!enable) begin
          state_d = StRampDown;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d  = '0;
          gain_d = gain_q + ONE;
          if (gain_q == UNITY - ONE) state_d = StRun;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StRun: begin
        gain_d = UNITY;
        div_d  = '0;
        if (!enable) state_d = StRampDown;
      end
      StRampDown: begin
        if (enable) begin
          state_d = StRampUp;
          div_d   = '0;
        end else if (gain_q == '0) begin
          state_d = StIdle;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d  = '0;
          gain_d = gain_q - ONE;
          if (gain_q == ONE) state_d = StIdle;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        div_d   = '0;
        gain_d  = '0;
      end
    endcase
  end

  // Status flags are registered from the next state so they change with it.
  always_comb begin
    busy_d = (state_d == StRampUp) || (state_d == StRampDown);
    full_d = (state_d == StRun);
  end

  assign gain      = gain_q;
  assign ramp_busy = busy_q;
  assign at_full   = full_q;

endmodule

// File: rtl/dac_softstart_gate.sv
// DAC output stage: scales offset-binary samples by a soft-start gain, 2-cycle registered path.
module dac_softstart_gate
  import octacq_dac_pkg::*;
#(
  parameter int unsigned DATA_W   = 14,
  parameter int unsigned GAIN_W   = 9,
  parameter int unsigned RAMP_DIV = 50
) (
  input  logic              clk50MHz,
  input  logic              rstn,
  input  logic [DATA_W-1:0] sine_in,
  input  logic              sine_valid,
  input  logic              enable,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic              ramp_busy,
  output logic              at_full
);

  localparam int unsigned       PROD_W = DATA_W + GAIN_W + 1;
  localparam logic [DATA_W-1:0] MID    = {1'b1, {(DATA_W - 1){1'b0}}};

  logic [GAIN_W-1:0]        gain;
  logic signed [DATA_W-1:0] s1_sample;
  logic signed [GAIN_W:0]   s1_gain;
  logic signed [PROD_W-1:0] prod_q;
  logic                     vld1_q;
  logic [DATA_W-1:0]        q_w;
  logic [DATA_W-1:0]        dac_q;
  logic                     dac_vld_q;

  gain_ramp_ctrl #(
    .GAIN_W   (GAIN_W),
    .RAMP_DIV (RAMP_DIV)
  ) u_ramp (
    .clk50MHz  (clk50MHz),
    .rstn      (rstn),
    .enable    (enable),
    .gain      (gain),
    .ramp_busy (ramp_busy),
    .at_full   (at_full)
  );

  // Offset binary to two's complement is an MSB flip.
  always_comb begin
    s1_sample = $signed({~sine_in[DATA_W-1], sine_in[DATA_W-2:0]});
    s1_gain   = $signed({1'b0, gain});
    q_w       = DATA_W'(prod_q >>> (GAIN_W - 1));
  end

  always_ff @(posedge clk50MHz or negedge rstn) begin
    if (!rstn) begin
      prod_q    <= '0;
      vld1_q    <= 1'b0;
      dac_q     <= MID;
      dac_vld_q <= 1'b0;
    end else begin
      prod_q    <= PROD_W'(s1_sample) * PROD_W'(s1_gain);
      vld1_q    <= sine_valid;
      dac_vld_q <= vld1_q;
      if (vld1_q) dac_q <= {~q_w[DATA_W-1], q_w[DATA_W-2:0]};
    end
  end

  assign dac_data  = dac_q;
  assign dac_valid = dac_vld_q;

endmodule

// File: tb/tb_dac_softstart_gate.sv
// Directed self-checking bench for dac_softstart_gate.
module tb_dac_softstart_gate;

  logic        clk50MHz = 1'b0;
  logic        rstn;
  logic [13:0] sine_in;
  logic        sine_valid;
  logic        enable;
  logic [13:0] dac_data;
  logic        dac_valid;
  logic        ramp_busy;
  logic        at_full;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk50MHz = ~clk50MHz;

  dac_softstart_gate dut (
    .clk50MHz   (clk50MHz),
    .rstn       (rstn),
    .sine_in    (sine_in),
    .sine_valid (sine_valid),
    .enable     (enable),
    .dac_data   (dac_data),
    .dac_valid  (dac_valid),
    .ramp_busy  (ramp_busy),
    .at_full    (at_full)
  );

  // Expected DAC word for a full-scale-positive input (14'h3FFF) at gain g.
  function automatic logic [13:0] exp_out(input int g);
    int v;
    v = 8192 + (8191 * g) / 256;
    return v[13:0];
  endfunction

  task automatic tick();
    @(posedge clk50MHz);
    #1;
  endtask

  task automatic rst_pulse();
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b0; sine_valid = 1'b1; sine_in = 14'h3FFF;
    tick(); tick();
    n_checks++; if (dac_data !== 14'h2000) begin n_errors++; $display("FAIL reset_dac got %h want 2000", dac_data); end
    n_checks++; if (dac_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", dac_valid); end
    n_checks++; if (ramp_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", ramp_busy); end
    n_checks++; if (at_full !== 1'b0) begin n_errors++; $display("FAIL reset_full got %b want 0", at_full); end
    rstn = 1'b1;
    tick();
    n_checks++; if (dac_valid !== 1'b0) begin n_errors++; $display("FAIL idle_valid_1 got %b want 0", dac_valid); end
    tick();
    n_checks++; if (dac_valid !== 1'b1) begin n_errors++; $display("FAIL idle_valid_2 got %b want 1", dac_valid); end
    n_checks++; if (dac_data !== 14'h2000) begin n_errors++; $display("FAIL idle_dac got %h want 2000", dac_data); end
  endtask

  task automatic test_ramp_up();
    enable = 1'b1;
    tick();
    n_checks++; if (ramp_busy !== 1'b1) begin n_errors++; $display("FAIL up_busy got %b want 1", ramp_busy); end
    for (int c = 1; c <= 12802; c++) begin
      tick();
      if (c == 51) begin
        n_checks++; if (dac_data !== 14'h2000) begin n_errors++; $display("FAIL up_g0 got %h want 2000", dac_data); end
      end
      if (c == 52) begin
        n_checks++; if (dac_data !== 14'h201F) begin n_errors++; $display("FAIL up_g1 got %h want 201f", dac_data); end
      end
      if (c == 6401) begin
        n_checks++; if (dac_data !== 14'h2FDF) begin n_errors++; $display("FAIL up_g127 got %h want 2fdf", dac_data); end
      end
      if (c == 6402) begin
        n_checks++; if (dac_data !== 14'h2FFF) begin n_errors++; $display("FAIL up_g128 got %h want 2fff", dac_data); end
      end
      if (c == 12799) begin
        n_checks++; if (at_full !== 1'b0 || ramp_busy !== 1'b1) begin
          n_errors++; $display("FAIL up_prefull got full=%b busy=%b want 0/1", at_full, ramp_busy); end
      end
      if (c == 12800) begin
        n_checks++; if (at_full !== 1'b1 || ramp_busy !== 1'b0) begin
          n_errors++; $display("FAIL up_full got full=%b busy=%b want 1/0", at_full, ramp_busy); end
      end
      if (c == 12802) begin
        n_checks++; if (dac_data !== 14'h3FFF) begin n_errors++; $display("FAIL up_unity got %h want 3fff", dac_data); end
      end
    end
  endtask

  task automatic test_run_sweep();
    logic [13:0] prev;
    prev = 14'h3FFF;
    for (int i = 0; i < 16384; i++) begin
      sine_in = 14'(i);
      tick();
      n_checks++; if (dac_data !== prev) begin
        n_errors++; $display("FAIL sweep_%0d got %h want %h", i, dac_data, prev); end
      prev = 14'(i);
    end
    sine_valid = 1'b0;
    tick();
    n_checks++; if (dac_data !== 14'h3FFF || dac_valid !== 1'b1) begin
      n_errors++; $display("FAIL sweep_last got %h/%b want 3fff/1", dac_data, dac_valid); end
    tick();
    n_checks++; if (dac_data !== 14'h3FFF || dac_valid !== 1'b0) begin
      n_errors++; $display("FAIL invalid_hold got %h/%b want 3fff/0", dac_data, dac_valid); end
  endtask

  task automatic test_async_reset();
    sine_valid = 1'b1; sine_in = 14'h1234;
    tick();
    sine_in = 14'h0ABC;
    tick();
    n_checks++; if (dac_data !== 14'h1234) begin n_errors++; $display("FAIL inflight got %h want 1234", dac_data); end
    #3 rstn = 1'b0;
    #1;
    n_checks++; if (dac_data !== 14'h2000 || dac_valid !== 1'b0) begin
      n_errors++; $display("FAIL async_rst got %h/%b want 2000/0", dac_data, dac_valid); end
    n_checks++; if (at_full !== 1'b0 || ramp_busy !== 1'b0) begin
      n_errors++; $display("FAIL async_rst_flags got full=%b busy=%b want 0/0", at_full, ramp_busy); end
    enable = 1'b0; sine_valid = 1'b0;
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (dac_valid !== 1'b0 || dac_data !== 14'h2000) begin
        n_errors++; $display("FAIL no_stale_%0d got %h/%b want 2000/0", k, dac_data, dac_valid); end
    end
    sine_valid = 1'b1; sine_in = 14'h3FFF;
  endtask

  task automatic test_ramp_abort();
    rst_pulse();
    enable = 1'b1;
    tick();
    for (int c = 1; c <= 5010; c++) tick();
    enable = 1'b0;
    tick();
    for (int d = 1; d <= 5002; d++) begin
      tick();
      if (d == 51) begin
        n_checks++; if (dac_data !== exp_out(100)) begin
          n_errors++; $display("FAIL abort_g100 got %h want %h", dac_data, exp_out(100)); end
      end
      if (d == 52) begin
        n_checks++; if (dac_data !== 14'h2C5F) begin n_errors++; $display("FAIL abort_g99 got %h want 2c5f", dac_data); end
      end
      if (d == 4999) begin
        n_checks++; if (ramp_busy !== 1'b1) begin n_errors++; $display("FAIL abort_busy got %b want 1", ramp_busy); end
      end
      if (d == 5000) begin
        n_checks++; if (ramp_busy !== 1'b0 || at_full !== 1'b0) begin
          n_errors++; $display("FAIL abort_idle got busy=%b full=%b want 0/0", ramp_busy, at_full); end
      end
      if (d == 5001) begin
        n_checks++; if (dac_data !== 14'h201F) begin n_errors++; $display("FAIL abort_g1 got %h want 201f", dac_data); end
      end
      if (d == 5002) begin
        n_checks++; if (dac_data !== 14'h2000) begin n_errors++; $display("FAIL abort_g0 got %h want 2000", dac_data); end
      end
    end
  endtask

  task automatic test_reenable();
    int prev;
    int diff;
    rst_pulse();
    enable = 1'b1;
    tick();
    for (int c = 1; c <= 2500; c++) tick();
    enable = 1'b0;
    prev = int'(dac_data);
    for (int d = 0; d <= 500; d++) begin
      tick();
      diff = int'(dac_data) - prev;
      n_checks++; if (diff > 32 || diff < -32) begin
        n_errors++; $display("FAIL down_step_%0d got %h from %h want step<=32", d, dac_data, prev[13:0]); end
      prev = int'(dac_data);
    end
    enable = 1'b1;
    for (int u = 0; u <= 60; u++) begin
      tick();
      diff = int'(dac_data) - prev;
      n_checks++; if (diff > 32 || diff < -32) begin
        n_errors++; $display("FAIL up_step_%0d got %h from %h want step<=32", u, dac_data, prev[13:0]); end
      prev = int'(dac_data);
      if (u == 2 || u == 51) begin
        n_checks++; if (dac_data !== 14'h24FF) begin
          n_errors++; $display("FAIL reen_g40_%0d got %h want 24ff", u, dac_data); end
      end
      if (u == 52) begin
        n_checks++; if (dac_data !== 14'h251F) begin n_errors++; $display("FAIL reen_g41 got %h want 251f", dac_data); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_run_sweep();
    test_async_reset();
    test_ramp_abort();
    test_reenable();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
